// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM and mult_div_unit.
// Width follows the unit's WIDTH parameter.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  // Handshake: start is a request that is taken only while the unit is idle
  // (busy low). Requests arriving while busy are dropped, not queued. done
  // pulses for exactly one cycle when HI/LO (or div_zero) have been updated.
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed mult/div unit owning HI/LO. One bit per cycle, 32 cycles.
// Divide datapath present only when MULTDIV_DIV_EN is defined; otherwise div flags div_zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mult_div_unit_if.slave       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               sign_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_signed;

`ifdef MULTDIV_DIV_EN
  logic               op_q;
  logic               rsign_q;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
`endif

  always_comb begin
    a_mag = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    b_mag = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
    // Multiplier bits sit in the low half of acc and shift out as the product shifts in.
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
    prod_signed = sign_q ? -acc_q : acc_q;
`ifdef MULTDIV_DIV_EN
    // acc = {remainder, dividend/quotient}; trial subtracts from the left-shifted remainder.
    trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (!trial[WIDTH]) div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else               div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    step_next = op_q ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      sign_q     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef MULTDIV_DIV_EN
      op_q       <= 1'b0;
      rsign_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            sign_q     <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
`ifdef MULTDIV_DIV_EN
            op_q    <= bus.op;
            rsign_q <= bus.operand_a[WIDTH-1];
            dz_q    <= bus.op && (bus.operand_b == '0);
            if (bus.op) begin
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
            state_q <= (bus.op && (bus.operand_b == '0)) ? S_FIX : S_RUN;
`else
            // Without the divider every div is answered like a divide by zero.
            dz_q    <= bus.op;
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            opnd_q  <= a_mag;
            state_q <= bus.op ? S_FIX : S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc_q <= step_next;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
          else                   cnt_q   <= cnt_q + 6'd1;
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (dz_q) begin
            div_zero_q <= 1'b1;
`ifdef MULTDIV_DIV_EN
          end else if (op_q) begin
            lo_q <= sign_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_q <= rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
          end else begin
            hi_q <= prod_signed[2*WIDTH-1:WIDTH];
            lo_q <= prod_signed[WIDTH-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, signed mult/div, divide by zero and start handshake.
module tb_mult_div_unit;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse, then waits (bounded) for done; lat counts edges after E0.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    tick();
    bus.start = 1'b0;
    lat = 0;
    busy_n = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (bus.busy === 1'b1) busy_n++;
    end
  endtask

  task automatic test_reset();
    int lat, bn, seen_done;
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'd0) begin errors++; $display("FAIL rst_hilo: got %h want 0", {bus.hi_out, bus.lo_out}); end
    reset_n = 1'b1;
    tick();
    run_op(1'b0, 32'h66, 32'h2AAAAAAB, lat, bn);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h00000011_00000022) begin errors++; $display("FAIL preload: got %h want 0000001100000022", {bus.hi_out, bus.lo_out}); end
    tick();
    // Start a mult and kill it with an asynchronous reset mid-cycle.
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'd5; bus.operand_b = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", bus.busy); end
    checks++; if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL async_flags: got dz=%b done=%b want 0 0", bus.div_zero, bus.done); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'd0) begin errors++; $display("FAIL async_hilo: got %h want 0", {bus.hi_out, bus.lo_out}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d want 0", dbg_state); end
    tick();
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    checks++; if (seen_done != 0 || bus.lo_out !== 32'd0) begin errors++; $display("FAIL discard: got activity=%0d lo=%h want 0 0", seen_done, bus.lo_out); end
    run_op(1'b0, 32'd3, 32'd4, lat, bn);
    checks++; if (lat != 33) begin errors++; $display("FAIL mul3x4_lat: got %0d want 33", lat); end
    checks++; if (bus.lo_out !== 32'd12 || bus.hi_out !== 32'd0) begin errors++; $display("FAIL mul3x4: got hi=%h lo=%h want 0 c", bus.hi_out, bus.lo_out); end
    tick();
  endtask

  task automatic test_signed_mult();
    int lat, bn;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, lat, bn);
    checks++; if (bn != 33) begin errors++; $display("FAIL smul_busy: got %0d want 33", bn); end
    checks++; if (lat != 33) begin errors++; $display("FAIL smul_lat: got %0d want 33", lat); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL smul: got %h want ffffffffffffffeb", {bus.hi_out, bus.lo_out}); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL smul_pulse: got %b want 0", bus.done); end
    run_op(1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, lat, bn);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0000001E) begin errors++; $display("FAIL negneg: got %h want 1e", {bus.hi_out, bus.lo_out}); end
    tick();
    repeat (10) tick();
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0000001E) begin errors++; $display("FAIL hold: got %h want 1e", {bus.hi_out, bus.lo_out}); end
  endtask

  task automatic test_extreme_mult();
    int lat, bn;
    run_op(1'b0, 32'h80000000, 32'h80000000, lat, bn);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h40000000_00000000) begin errors++; $display("FAIL xmul: got %h want 4000000000000000", {bus.hi_out, bus.lo_out}); end
    tick();
  endtask

  task automatic test_signed_div();
    int lat, bn;
`ifdef MULTDIV_DIV_EN
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bn);
    checks++; if (lat != 33) begin errors++; $display("FAIL sdiv_lat: got %0d want 33", lat); end
    checks++; if (bus.lo_out !== 32'hFFFFFFFD || bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL sdiv: got hi=%h lo=%h want ffffffff fffffffd", bus.hi_out, bus.lo_out); end
    tick();
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bn);
    checks++; if (bus.lo_out !== 32'h80000000 || bus.hi_out !== 32'd0) begin errors++; $display("FAIL ovfdiv: got hi=%h lo=%h want 0 80000000", bus.hi_out, bus.lo_out); end
    tick();
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, lat, bn);
    checks++; if (bus.lo_out !== 32'hFFFFFFF2 || bus.hi_out !== 32'd2) begin errors++; $display("FAIL div100: got hi=%h lo=%h want 2 fffffff2", bus.hi_out, bus.lo_out); end
    tick();
    run_op(1'b1, 32'd9, 32'd3, lat, bn);
    checks++; if (bus.lo_out !== 32'd3 || bus.hi_out !== 32'd0 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL div9: got hi=%h lo=%h dz=%b want 0 3 0", bus.hi_out, bus.lo_out, bus.div_zero); end
    tick();
`else
    // Divider absent: any div is answered one edge later with div_zero and HI/LO untouched.
    run_op(1'b0, 32'd4, 32'd5, lat, bn);
    tick();
    run_op(1'b1, 32'd9, 32'd3, lat, bn);
    checks++; if (lat != 1 || bn != 1) begin errors++; $display("FAIL nodiv_lat: got lat=%0d busy=%0d want 1 1", lat, bn); end
    checks++; if (bus.div_zero !== 1'b1 || bus.lo_out !== 32'd20 || bus.hi_out !== 32'd0) begin errors++; $display("FAIL nodiv: got dz=%b hi=%h lo=%h want 1 0 14", bus.div_zero, bus.hi_out, bus.lo_out); end
    tick();
`endif
  endtask

  task automatic test_div_zero();
    int lat, bn;
    run_op(1'b0, 32'h66, 32'h2AAAAAAB, lat, bn);
    tick();
    run_op(1'b1, 32'd5, 32'd0, lat, bn);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_lat: got %0d want 1", lat); end
    checks++; if (bn != 1) begin errors++; $display("FAIL dz_busy: got %0d want 1", bn); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", bus.div_zero); end
    checks++; if (bus.hi_out !== 32'h11 || bus.lo_out !== 32'h22) begin errors++; $display("FAIL dz_hilo: got hi=%h lo=%h want 11 22", bus.hi_out, bus.lo_out); end
    repeat (3) tick();
    checks++; if (bus.div_zero !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL dz_hold: got dz=%b done=%b want 1 0", bus.div_zero, bus.done); end
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b want 0", bus.div_zero); end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin tick(); lat++; end
    checks++; if (lat != 33 || bus.lo_out !== 32'd6) begin errors++; $display("FAIL dz_next: got lat=%0d lo=%h want 33 6", lat, bus.lo_out); end
    tick();
  endtask

  task automatic test_handshake();
    int lat;
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'h12345678; bus.operand_b = 32'h10;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'd2; bus.operand_b = 32'd2;
    tick();
    bus.start = 1'b0;
    lat = 10;
    while (bus.done !== 1'b1 && lat < 100) begin tick(); lat++; end
    checks++; if (lat != 33) begin errors++; $display("FAIL busy_start_lat: got %0d want 33", lat); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h00000001_23456780) begin errors++; $display("FAIL busy_start: got %h want 0000000123456780", {bus.hi_out, bus.lo_out}); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL no_queue: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    run_op(1'b0, 32'd6, 32'd7, lat, bn);
    checks++; if (bus.lo_out !== 32'd42) begin errors++; $display("FAIL b2b_first: got %h want 2a", bus.lo_out); end
    run_op(1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF, lat, bn);
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_lat: got %0d want 33", lat); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFFFFFF_80000001) begin errors++; $display("FAIL b2b: got %h want ffffffff80000001", {bus.hi_out, bus.lo_out}); end
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    test_reset();
    test_signed_mult();
    test_extreme_mult();
    test_signed_div();
    test_div_zero();
    test_handshake();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
